// File: rtl/riscv_aes_wb_pkg.sv
// -----------------------------------------------------------------------------
// riscv_aes_wb_pkg
// Shared types and helpers for the AES coprocessor write-back sequencer.
//   - wb_state_e  : sequencer FSM states (IDLE, REQ, DRAIN, FINISH)
//   - AES_BLOCK_W : default AES result width (one 128-bit state)
//   - bswap()     : byte reversal of the low nbytes bytes of a vector, used
//                   when the design is built with AES_WB_BSWAP_EN defined
// -----------------------------------------------------------------------------
package riscv_aes_wb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } wb_state_e;

  localparam int AES_BLOCK_W = 128;

  // Widest beat the byte-swap helper can handle.
  localparam int BSWAP_MAX_W = 512;

  // Reverse byte order of d[nbytes*8-1:0]; upper bytes of the result are zero.
  function automatic logic [BSWAP_MAX_W-1:0] bswap(input logic [BSWAP_MAX_W-1:0] d,
                                                   input int nbytes);
    logic [BSWAP_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BSWAP_MAX_W / 8; i++) begin
      if (i < nbytes) begin
        r[i*8 +: 8] = d[(nbytes-1-i)*8 +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/riscv_aes_wb_outstanding.sv
// -----------------------------------------------------------------------------
// riscv_aes_wb_outstanding
// Up/down counter of write beats that were granted but not yet acknowledged.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_i       : synchronous clear (new transfer starting)
//   inc_i       : a beat was granted this cycle
//   dec_i       : a write response (rvalid) arrived this cycle
//   zero_o      : counter value after this cycle's update is zero
// A response with nothing outstanding is ignored and flagged by an assertion.
// -----------------------------------------------------------------------------
module riscv_aes_wb_outstanding
  import riscv_aes_wb_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_eff;

  // Stray responses must not wrap the counter.
  assign dec_eff = dec_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_eff) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!inc_i && dec_eff) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Looks at the next value so the sequencer can leave DRAIN in the same
  // cycle as the final response.
  assign zero_o = (cnt_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(dec_i && (cnt_q == '0)))
    else $error("riscv_aes_wb_outstanding: rvalid with no outstanding beat");

endmodule

// File: rtl/riscv_aes_wb_seq.sv
// -----------------------------------------------------------------------------
// riscv_aes_wb_seq
// Write-back sequencer for the AES coprocessor result path. On start_i the
// DATA_W-bit result and base address are captured, then written to memory as
// NUM_BEATS = DATA_W/BEAT_W consecutive beats over the req/gnt/rvalid data
// port. busy_o halts the core until every beat is granted and acknowledged;
// done_o then pulses for one cycle.
//
// Build option: AES_WB_BSWAP_EN -- when defined each beat is byte-reversed on
// data_wdata_o (big-endian AES state to little-endian memory). Beat order,
// addresses, ports and timing are unaffected.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start_i          : start request (sampled only in IDLE)
//   addr_i, data_i   : base byte address and result word
//   busy_o           : core halt request, high whenever not IDLE
//   data_req_o       : beat request valid
//   data_gnt_i       : beat grant (accepted when req && gnt)
//   data_we_o        : write enable (mirrors data_req_o)
//   data_addr_o      : beat byte address
//   data_wdata_o     : beat data
//   data_be_o        : byte enables (all ones while requesting)
//   data_rvalid_i    : write response, one per granted beat
//   done_o           : one-cycle completion pulse
// -----------------------------------------------------------------------------
module riscv_aes_wb_seq
  import riscv_aes_wb_pkg::*;
#(
  parameter int DATA_W      = AES_BLOCK_W,
  parameter int BEAT_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int ADDR_STRIDE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic                busy_o,
  output logic                data_req_o,
  input  logic                data_gnt_i,
  output logic                data_we_o,
  output logic [ADDR_W-1:0]   data_addr_o,
  output logic [BEAT_W-1:0]   data_wdata_o,
  output logic [BEAT_W/8-1:0] data_be_o,
  input  logic                data_rvalid_i,
  output logic                done_o
);

  localparam int NUM_BEATS = DATA_W / BEAT_W;
  localparam int CNT_W     = $clog2(NUM_BEATS + 1);
  localparam int BE_W      = BEAT_W / 8;

  if ((DATA_W % BEAT_W) != 0 || NUM_BEATS < 1) begin : g_bad_width
    $error("riscv_aes_wb_seq: DATA_W must be a non-zero multiple of BEAT_W");
  end
  if (BEAT_W > BSWAP_MAX_W) begin : g_bad_beat
    $error("riscv_aes_wb_seq: BEAT_W exceeds BSWAP_MAX_W");
  end

  wb_state_e         state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              beat_acc;
  logic              out_clr;
  logic              out_zero;
  logic [BEAT_W-1:0] beat_sel;
  logic [BEAT_W-1:0] beat_fmt;

  assign beat_acc = (state_q == REQ) && data_gnt_i;

  riscv_aes_wb_outstanding #(
    .CNT_W (CNT_W)
  ) u_outstanding (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (out_clr),
    .inc_i  (beat_acc),
    .dec_i  (data_rvalid_i),
    .zero_o (out_zero)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    data_d  = data_q;
    addr_d  = addr_q;
    out_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          data_d  = data_i;
          addr_d  = addr_i;
          beat_d  = '0;
          out_clr = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (data_gnt_i) begin
          beat_d = beat_q + CNT_W'(1);
          if (beat_q == CNT_W'(NUM_BEATS - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_zero) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  // Beat selection uses constant part-selects so no variable shifter is built.
  always_comb begin
    beat_sel = '0;
    for (int k = 0; k < NUM_BEATS; k++) begin
      if (beat_q == CNT_W'(k)) begin
        beat_sel = data_q[k*BEAT_W +: BEAT_W];
      end
    end
  end

`ifdef AES_WB_BSWAP_EN
  assign beat_fmt = BEAT_W'(bswap(BSWAP_MAX_W'(beat_sel), BE_W));
`else
  assign beat_fmt = beat_sel;
`endif

  // Bus outputs are zero outside REQ so reset and idle look identical.
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == FINISH);
  assign data_req_o   = (state_q == REQ);
  assign data_we_o    = data_req_o;
  assign data_addr_o  = data_req_o ? (addr_q + ADDR_W'(beat_q) * ADDR_W'(ADDR_STRIDE)) : '0;
  assign data_wdata_o = data_req_o ? beat_fmt : '0;
  assign data_be_o    = {BE_W{data_req_o}};

endmodule

// File: tb/tb_riscv_aes_wb_seq.sv
module tb_riscv_aes_wb_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;

  // Instance 1: default 128/32/4
  logic         start = 1'b0;
  logic [31:0]  addr  = '0;
  logic [127:0] data  = '0;
  logic         gnt    = 1'b0;
  logic         rvalid = 1'b0;
  logic         busy, req, we, done;
  logic [31:0]  daddr, wdata;
  logic [3:0]   be;

  // Instance 2: 256/64/8
  logic         start2 = 1'b0;
  logic [31:0]  addr2  = '0;
  logic [255:0] data2  = '0;
  logic         gnt2    = 1'b0;
  logic         rvalid2 = 1'b0;
  logic         busy2, req2, we2, done2;
  logic [31:0]  daddr2;
  logic [63:0]  wdata2;
  logic [7:0]   be2;

  riscv_aes_wb_seq dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .addr_i(addr), .data_i(data),
    .busy_o(busy), .data_req_o(req), .data_gnt_i(gnt), .data_we_o(we),
    .data_addr_o(daddr), .data_wdata_o(wdata), .data_be_o(be),
    .data_rvalid_i(rvalid), .done_o(done)
  );

  riscv_aes_wb_seq #(.DATA_W(256), .BEAT_W(64), .ADDR_W(32), .ADDR_STRIDE(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .addr_i(addr2), .data_i(data2),
    .busy_o(busy2), .data_req_o(req2), .data_gnt_i(gnt2), .data_we_o(we2),
    .data_addr_o(daddr2), .data_wdata_o(wdata2), .data_be_o(be2),
    .data_rvalid_i(rvalid2), .done_o(done2)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } beat_t;
  typedef struct packed { logic [31:0] a; logic [63:0] d; } beat2_t;
  typedef struct packed { int s; int d; } txn_t;
  typedef logic [31:0] w4_t [4];

  beat_t  beatq[$];
  beat2_t beat2q[$];
  txn_t   txnq[$];
  int     done2_exp = 0;
  int     done2_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [31:0] sw32(input logic [31:0] d);
`ifdef AES_WB_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // Memory model for instance 1: optional stall on one beat, rvalid a fixed
  // number of cycles after each grant.
  int rdelay = 1;
  int stall_beat = 1;
  int stall_left = 0;
  int gcnt = 0;
  int pend[$];

  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      pend.delete();
      gnt = 1'b0;
      rvalid = 1'b0;
    end else begin
      rvalid = (pend.size() > 0) && (pend[0] == cyc);
      if (rvalid) void'(pend.pop_front());
      if (req && gcnt == stall_beat && stall_left > 0) begin
        gnt = 1'b0;
        stall_left--;
      end else begin
        gnt = 1'b1;
        if (req) begin
          pend.push_back(cyc + rdelay);
          gcnt++;
        end
      end
    end
  end

  // Memory model for instance 2: always granting, rvalid one cycle later.
  logic r2 = 1'b0;
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      gnt2 = 1'b0; rvalid2 = 1'b0; r2 = 1'b0;
    end else begin
      gnt2 = 1'b1;
      rvalid2 = r2;
      r2 = req2;
    end
  end

  // Monitor for instance 1
  bit prev_busy = 1'b0;
  bit after_done = 1'b0;
  int busy_rise = 0;
  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      prev_busy = 1'b0;
      after_done = 1'b0;
    end else begin
      if (after_done) chk("busy_after_done", 64'(busy), 64'd0);
      after_done = 1'b0;
      if (busy && !prev_busy) busy_rise = cyc;
      prev_busy = busy;
      if (req) begin
        if (beatq.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          chk("beat_addr", 64'(daddr), 64'(beatq[0].a));
          chk("beat_data", 64'(wdata), 64'(beatq[0].d));
          if (gnt) begin
            chk("we_be", 64'({we, be}), 64'h1F);
            void'(beatq.pop_front());
          end
        end
      end
      if (done) begin
        if (txnq.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          chk("done_cycle", 64'(cyc), 64'(txnq[0].d));
          chk("busy_rise_cycle", 64'(busy_rise), 64'(txnq[0].s + 1));
          chk("busy_at_done", 64'(busy), 64'd1);
          void'(txnq.pop_front());
          after_done = 1'b1;
        end
      end
    end
  end

  // Monitor for instance 2
  always begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      if (req2) begin
        if (beat2q.size() == 0) begin
          fail_now("unexpected_beat2");
        end else begin
          chk("beat2_addr", 64'(daddr2), 64'(beat2q[0].a));
          chk("beat2_data", wdata2, beat2q[0].d);
          chk("beat2_we_be", 64'({we2, be2}), 64'h1FF);
          void'(beat2q.pop_front());
        end
      end
      if (done2) begin
        chk("done2_cycle", 64'(cyc), 64'(done2_exp));
        chk("busy2_at_done", 64'(busy2), 64'd1);
        done2_seen++;
      end
    end
  end

  task automatic push_beats(input w4_t ea, input w4_t ed);
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      b.a = ea[k];
      b.d = sw32(ed[k]);
      beatq.push_back(b);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (txnq.size() > 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (txnq.size() > 0) begin
      fail_now({nm, "_timeout"});
      txnq.delete();
      beatq.delete();
    end
    chk({nm, "_beats_left"}, 64'(beatq.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input string nm, input logic [31:0] a, input logic [127:0] d,
                     input w4_t ea, input w4_t ed, input int rd, input int st,
                     input int lat, input bit inject);
    txn_t t;
    @(negedge clk);
    rdelay = rd;
    stall_left = st;
    gcnt = 0;
    start = 1'b1;
    addr = a;
    data = d;
    push_beats(ea, ed);
    t.s = cyc;
    t.d = cyc + lat;
    txnq.push_back(t);
    @(negedge clk);
    start = 1'b0;
    addr = 32'hDEAD_0000;
    data = '1;
    if (inject) begin
      start = 1'b1;
      addr = 32'h5000;
      data = 128'hFFFF0000_EEEE1111_DDDD2222_CCCC3333;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    txn_t t;
    beat2_t b2;
    int n;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_req",   64'(req),   64'd0);
    chk("rst_we",    64'(we),    64'd0);
    chk("rst_addr",  64'(daddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_be",    64'(be),    64'd0);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst2_outs", 64'({busy2, req2, we2, done2, be2}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run("basic", 32'h1000, 128'h00112233_44556677_8899AABB_CCDDEEFF,
        '{32'h1000, 32'h1004, 32'h1008, 32'h100C},
        '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233}, 1, 0, 6, 1'b0);

    run("stall", 32'h1000, 128'h00112233_44556677_8899AABB_CCDDEEFF,
        '{32'h1000, 32'h1004, 32'h1008, 32'h100C},
        '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233}, 1, 3, 9, 1'b0);

    run("slow_rvalid", 32'h3000, 128'h0F0E0D0C_0B0A0908_07060504_03020100,
        '{32'h3000, 32'h3004, 32'h3008, 32'h300C},
        '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C}, 5, 0, 10, 1'b0);

    run("wrap", 32'hFFFFFFF8, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3,
        '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004},
        '{32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0}, 1, 0, 6, 1'b0);

    run("start_ignored", 32'h4000, 128'h11111111_22222222_33333333_44444444,
        '{32'h4000, 32'h4004, 32'h4008, 32'h400C},
        '{32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 1, 0, 6, 1'b1);

    // Reset while in DRAIN (slow responses keep it there)
    @(negedge clk);
    rdelay = 5;
    stall_left = 0;
    gcnt = 0;
    start = 1'b1;
    addr = 32'h6000;
    data = 128'h01010101_02020202_03030303_04040404;
    push_beats('{32'h6000, 32'h6004, 32'h6008, 32'h600C},
               '{32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101});
    t.s = cyc;
    t.d = cyc + 10;
    txnq.push_back(t);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("drain_busy_before_rst", 64'({busy, req, done}), 64'h4);
    chk("drain_beats_sent", 64'(beatq.size()), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outs", 64'({busy, req, we, done, be}), 64'd0);
    chk("arst_addr_data", {daddr, wdata}, 64'd0);
    txnq.delete();
    beatq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run("after_reset", 32'h8000, 128'h00112233_44556677_8899AABB_CCDDEEFF,
        '{32'h8000, 32'h8004, 32'h8008, 32'h800C},
        '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233}, 2, 0, 7, 1'b0);

    // Wide instance: 4 beats of 64 bits at stride 8
    @(negedge clk);
    start2 = 1'b1;
    addr2 = 32'h2000;
    data2 = 256'h0001020304050607_08090A0B0C0D0E0F_1011121314151617_18191A1B1C1D1E1F;
`ifdef AES_WB_BSWAP_EN
    b2.a = 32'h2000; b2.d = 64'h1F1E1D1C1B1A1918; beat2q.push_back(b2);
    b2.a = 32'h2008; b2.d = 64'h1716151413121110; beat2q.push_back(b2);
    b2.a = 32'h2010; b2.d = 64'h0F0E0D0C0B0A0908; beat2q.push_back(b2);
    b2.a = 32'h2018; b2.d = 64'h0706050403020100; beat2q.push_back(b2);
`else
    b2.a = 32'h2000; b2.d = 64'h18191A1B1C1D1E1F; beat2q.push_back(b2);
    b2.a = 32'h2008; b2.d = 64'h1011121314151617; beat2q.push_back(b2);
    b2.a = 32'h2010; b2.d = 64'h08090A0B0C0D0E0F; beat2q.push_back(b2);
    b2.a = 32'h2018; b2.d = 64'h0001020304050607; beat2q.push_back(b2);
`endif
    done2_exp = cyc + 6;
    @(negedge clk);
    start2 = 1'b0;
    data2 = '0;
    n = 0;
    while (done2_seen == 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("wide_done_count", 64'(done2_seen), 64'd1);
    chk("wide_beats_left", 64'(beat2q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
